// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: data width, decode control bundle layout and
// register-index helpers used by the ID/EX stage and its hazard comparator.
package riscv_pipe_pkg;

    localparam int unsigned XLEN = 64;

    // Decode control bundle layout
    localparam int unsigned CTRL_W       = 12;
    localparam int unsigned REGWRITE_BIT = 0;
    localparam int unsigned MEMWRITE_BIT = 1;
    localparam int unsigned MEMTOREG_BIT = 2;
    localparam int unsigned MEMREAD_BIT  = 3;
    localparam int unsigned ALUSRC_BIT   = 4;
    localparam int unsigned ALUOP_LSB    = 5;
    localparam int unsigned ALUOP_W      = 4;
    localparam int unsigned BRANCH_BIT   = 9;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD  = 4'd0,
        ALUOP_SUB  = 4'd1,
        ALUOP_AND  = 4'd2,
        ALUOP_OR   = 4'd3,
        ALUOP_XOR  = 4'd4,
        ALUOP_SLL  = 4'd5,
        ALUOP_SRL  = 4'd6,
        ALUOP_SRA  = 4'd7,
        ALUOP_SLT  = 4'd8,
        ALUOP_SLTU = 4'd9
    } aluop_e;

    // True when the write-back port is writing register rs this cycle (x0 never counts).
    function automatic logic wb_hits(input logic we, input reg_idx_t wb_rd, input reg_idx_t rs);
        return we && (wb_rd != REG_ZERO) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decode inputs, write-back snoop, and registered EX outputs.
// master = decode/control side, slave = the ID/EX stage register.
interface id_ex_stage_reg_if #(
    parameter int unsigned XLEN   = riscv_pipe_pkg::XLEN,
    parameter int unsigned CTRL_W = riscv_pipe_pkg::CTRL_W
);
    import riscv_pipe_pkg::*;

    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    reg_idx_t          id_rs1;
    reg_idx_t          id_rs2;
    reg_idx_t          id_rd;
    logic [XLEN-1:0]   id_imm;
    logic [XLEN-1:0]   id_readdata1;
    logic [XLEN-1:0]   id_readdata2;
    logic [CTRL_W-1:0] id_ctrl;

    logic              wb_registerwrite;
    reg_idx_t          wb_rd;
    logic [XLEN-1:0]   wb_writedata;

    logic              hazard_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_data1;
    logic [XLEN-1:0]   ex_data2;
    reg_idx_t          ex_rs1;
    reg_idx_t          ex_rs2;
    reg_idx_t          ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm,
               id_readdata1, id_readdata2, id_ctrl,
               wb_registerwrite, wb_rd, wb_writedata,
        input  hazard_stall, ex_valid, ex_pc, ex_imm, ex_data1, ex_data2,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm,
               id_readdata1, id_readdata2, id_ctrl,
               wb_registerwrite, wb_rd, wb_writedata,
        output hazard_stall, ex_valid, ex_pc, ex_imm, ex_data1, ex_data2,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl
    );

endinterface

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use comparator: a load sitting in EX whose destination feeds the
// instruction in ID forces a one-cycle bubble and an upstream hold.
module hazard_detect
    import riscv_pipe_pkg::*;
(
    input  logic     ex_valid_i,
    input  logic     ex_memread_i,
    input  reg_idx_t ex_rd_i,
    input  logic     id_valid_i,
    input  reg_idx_t id_rs1_i,
    input  reg_idx_t id_rs2_i,
    input  logic     flush_i,
    input  logic     stall_i,
    output logic     hazard_stall_o
);

    logic rd_match;

    assign rd_match = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);

    // Flush and downstream stall both suppress the hazard request.
    assign hazard_stall_o = ex_valid_i && ex_memread_i && (ex_rd_i != REG_ZERO)
                         && id_valid_i && rd_match && !flush_i && !stall_i;

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion, flush/stall
// handling and optional write-back bypass (enabled by defining IDEX_WB_BYPASS_EN).
module id_ex_stage_reg #(
    parameter int unsigned XLEN        = riscv_pipe_pkg::XLEN,
    parameter int unsigned CTRL_W      = riscv_pipe_pkg::CTRL_W,
    parameter int unsigned MEMREAD_BIT = riscv_pipe_pkg::MEMREAD_BIT
) (
    input  logic             clk,
    input  logic             reset,
    id_ex_stage_reg_if.slave bus
);
    import riscv_pipe_pkg::*;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q,    pc_d;
    logic [XLEN-1:0]   imm_q,   imm_d;
    logic [XLEN-1:0]   data1_q, data1_d;
    logic [XLEN-1:0]   data2_q, data2_d;
    reg_idx_t          rs1_q,   rs1_d;
    reg_idx_t          rs2_q,   rs2_d;
    reg_idx_t          rd_q,    rd_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    logic              hazard;
    logic              kill;

    hazard_detect u_hazard_detect (
        .ex_valid_i     (valid_q),
        .ex_memread_i   (ctrl_q[MEMREAD_BIT]),
        .ex_rd_i        (rd_q),
        .id_valid_i     (bus.id_valid),
        .id_rs1_i       (bus.id_rs1),
        .id_rs2_i       (bus.id_rs2),
        .flush_i        (bus.flush),
        .stall_i        (bus.stall),
        .hazard_stall_o (hazard)
    );

    // hazard already excludes stall and flush, so flush and load-use share one
    // bubble path ahead of the stall branch without changing priority.
    assign kill = bus.flush || hazard;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        data1_d = data1_q;
        data2_d = data2_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;

        if (kill) begin
            valid_d = 1'b0;
            pc_d    = '0;
            imm_d   = '0;
            data1_d = '0;
            data2_d = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = '0;
        end else if (bus.stall) begin
`ifdef IDEX_WB_BYPASS_EN
            // Held operands track write-backs so they are current when the stall lifts.
            if (valid_q && wb_hits(bus.wb_registerwrite, bus.wb_rd, rs1_q)) begin
                data1_d = bus.wb_writedata;
            end
            if (valid_q && wb_hits(bus.wb_registerwrite, bus.wb_rd, rs2_q)) begin
                data2_d = bus.wb_writedata;
            end
`endif
        end else begin
            valid_d = bus.id_valid;
            pc_d    = bus.id_pc;
            imm_d   = bus.id_imm;
            rs1_d   = bus.id_rs1;
            rs2_d   = bus.id_rs2;
            rd_d    = bus.id_rd;
            ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
`ifdef IDEX_WB_BYPASS_EN
            // Register file writes at the same edge, so its read port is one write behind.
            data1_d = wb_hits(bus.wb_registerwrite, bus.wb_rd, bus.id_rs1) ? bus.wb_writedata
                                                                           : bus.id_readdata1;
            data2_d = wb_hits(bus.wb_registerwrite, bus.wb_rd, bus.id_rs2) ? bus.wb_writedata
                                                                           : bus.id_readdata2;
`else
            data1_d = bus.id_readdata1;
            data2_d = bus.id_readdata2;
`endif
        end
    end

`ifndef IDEX_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{bus.wb_registerwrite, bus.wb_rd, bus.wb_writedata};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.hazard_stall = hazard;
    assign bus.ex_valid     = valid_q;
    assign bus.ex_pc        = pc_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_data1     = data1_q;
    assign bus.ex_data2     = data2_q;
    assign bus.ex_rs1       = rs1_q;
    assign bus.ex_rs2       = rs2_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_ctrl      = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed vector table followed by a random run
// checked against a register-file-level reference model.
module tb_id_ex_stage_reg;
    import riscv_pipe_pkg::*;

    localparam logic [CTRL_W-1:0] C_LOAD = CTRL_W'((1 << REGWRITE_BIT) | (1 << MEMTOREG_BIT) | (1 << MEMREAD_BIT));
    localparam logic [CTRL_W-1:0] C_ALU  = CTRL_W'((1 << REGWRITE_BIT) | (int'(ALUOP_SUB) << ALUOP_LSB));
    localparam logic [CTRL_W-1:0] C_STORE = CTRL_W'((1 << MEMWRITE_BIT) | (1 << ALUSRC_BIT) | (1 << BRANCH_BIT));

    typedef struct packed {
        logic              v;
        logic [63:0]       pc, imm, d1, d2;
        reg_idx_t          rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
    } slot_t;

    typedef struct packed {
        logic              rst, stall, flush, idv;
        logic [63:0]       pc, imm, rd1, rd2;
        reg_idx_t          rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        logic              wbwe;
        reg_idx_t          wbrd;
        logic [63:0]       wbdata;
    } in_t;

    typedef struct {
        in_t   in;
        logic  haz;
        slot_t exp;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    id_ex_stage_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .MEMREAD_BIT(MEMREAD_BIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_slot(input string tag, input slot_t e);
        cmp({tag, ".ex_valid"}, 64'(bus.ex_valid), 64'(e.v));
        cmp({tag, ".ex_pc"},    bus.ex_pc,         e.pc);
        cmp({tag, ".ex_imm"},   bus.ex_imm,        e.imm);
        cmp({tag, ".ex_data1"}, bus.ex_data1,      e.d1);
        cmp({tag, ".ex_data2"}, bus.ex_data2,      e.d2);
        cmp({tag, ".ex_rs1"},   64'(bus.ex_rs1),   64'(e.rs1));
        cmp({tag, ".ex_rs2"},   64'(bus.ex_rs2),   64'(e.rs2));
        cmp({tag, ".ex_rd"},    64'(bus.ex_rd),    64'(e.rd));
        cmp({tag, ".ex_ctrl"},  64'(bus.ex_ctrl),  64'(e.ctrl));
    endtask

    task automatic drive(input in_t i);
        reset                = i.rst;
        bus.stall            = i.stall;
        bus.flush            = i.flush;
        bus.id_valid         = i.idv;
        bus.id_pc            = i.pc;
        bus.id_imm           = i.imm;
        bus.id_readdata1     = i.rd1;
        bus.id_readdata2     = i.rd2;
        bus.id_rs1           = i.rs1;
        bus.id_rs2           = i.rs2;
        bus.id_rd            = i.rd;
        bus.id_ctrl          = i.ctrl;
        bus.wb_registerwrite = i.wbwe;
        bus.wb_rd            = i.wbrd;
        bus.wb_writedata     = i.wbdata;
    endtask

    function automatic in_t mk(input logic idv, input logic [63:0] pc, input reg_idx_t rs1,
                               input reg_idx_t rs2, input reg_idx_t rd, input logic [63:0] rd1,
                               input logic [63:0] rd2, input logic [CTRL_W-1:0] ctrl);
        in_t i = '0;
        i.idv  = idv;
        i.pc   = pc;
        i.imm  = 64'hFFFF_FFFF_FFFF_F000 | pc;
        i.rs1  = rs1;
        i.rs2  = rs2;
        i.rd   = rd;
        i.rd1  = rd1;
        i.rd2  = rd2;
        i.ctrl = ctrl;
        return i;
    endfunction

    // Expected EX slot after a normal load of i with the given operand values.
    function automatic slot_t ld(input in_t i, input logic [63:0] d1, input logic [63:0] d2);
        slot_t s;
        s.v    = i.idv;
        s.pc   = i.pc;
        s.imm  = i.imm;
        s.d1   = d1;
        s.d2   = d2;
        s.rs1  = i.rs1;
        s.rs2  = i.rs2;
        s.rd   = i.rd;
        s.ctrl = i.idv ? i.ctrl : '0;
        return s;
    endfunction

    // ---------------- reference model ----------------
    logic [63:0] rf [32];

    function automatic logic model_hazard(input slot_t m, input in_t i);
        return m.v && m.ctrl[MEMREAD_BIT] && (m.rd != 0) && i.idv
            && ((m.rd == i.rs1) || (m.rd == i.rs2)) && !i.flush && !i.stall;
    endfunction

    function automatic slot_t model_next(input slot_t m, input in_t i);
        slot_t       n = m;
        logic [63:0] newest [32];
        newest = rf;
        if (i.wbwe && i.wbrd != 0) newest[i.wbrd] = i.wbdata;
        if (i.rst || i.flush || model_hazard(m, i)) return '0;
        if (i.stall) begin
`ifdef IDEX_WB_BYPASS_EN
            if (m.v && i.wbwe && i.wbrd != 0) begin
                if (i.wbrd == m.rs1) n.d1 = newest[m.rs1];
                if (i.wbrd == m.rs2) n.d2 = newest[m.rs2];
            end
`endif
            return n;
        end
`ifdef IDEX_WB_BYPASS_EN
        n = ld(i, (i.rs1 == 0) ? i.rd1 : newest[i.rs1], (i.rs2 == 0) ? i.rd2 : newest[i.rs2]);
`else
        n = ld(i, i.rd1, i.rd2);
`endif
        return n;
    endfunction

    vec_t tbl[$];

    task automatic add(input in_t i, input logic haz, input slot_t e);
        vec_t v;
        v.in  = i;
        v.haz = haz;
        v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        in_t   i;
        slot_t e;
        slot_t m;
        n_cmp = 0;
        n_bad = 0;

        // ---- directed vectors (rows are consecutive cycles) ----
        i = '0; i.rst = 1'b1; add(i, 1'b0, '0);
        i = mk(1, 'h40, 5, 6, 10, 'h55, 'h66, C_ALU);   add(i, 1'b0, ld(i, 'h55, 'h66));
        i = mk(1, 'h44, 1, 2, 7, 'h11, 'h22, C_LOAD);   add(i, 1'b0, ld(i, 'h11, 'h22));
        i = mk(1, 'h48, 3, 7, 8, 'h33, 'h77, C_ALU);    add(i, 1'b1, '0);
                                                        add(i, 1'b0, ld(i, 'h33, 'h77));
        i = mk(1, 'h4C, 9, 9, 11, 'h9, 'h9, C_ALU);
        i.wbwe = 1'b1; i.wbrd = 9; i.wbdata = 'hDEAD;
`ifdef IDEX_WB_BYPASS_EN
        add(i, 1'b0, ld(i, 'hDEAD, 'hDEAD));
`else
        add(i, 1'b0, ld(i, 'h9, 'h9));
`endif
        i = mk(1, 'h50, 0, 0, 12, 'h123, 'h456, C_STORE);
        i.wbwe = 1'b1; i.wbrd = 0; i.wbdata = 'hBEEF;   add(i, 1'b0, ld(i, 'h123, 'h456));
        // stall for two cycles while WB writes x4
        i = mk(1, 'h54, 3, 4, 13, 'h30, 'h40, C_ALU);   e = ld(i, 'h30, 'h40); add(i, 1'b0, e);
        i = mk(1, 'h99, 4, 13, 4, 'hAA, 'hBB, C_LOAD);
        i.stall = 1'b1; i.wbwe = 1'b1; i.wbrd = 4; i.wbdata = 'h1234;
`ifdef IDEX_WB_BYPASS_EN
        e.d2 = 'h1234;
`endif
        add(i, 1'b0, e);
        i.wbwe = 1'b0; i.wbrd = 0; i.wbdata = '0;       add(i, 1'b0, e);
        // flush + stall with a pending load-use
        i = mk(1, 'h60, 1, 2, 14, 'h1, 'h2, C_LOAD);    add(i, 1'b0, ld(i, 'h1, 'h2));
        i = mk(1, 'h64, 14, 3, 5, 'h5, 'h6, C_ALU);
        i.stall = 1'b1; i.flush = 1'b1;                 add(i, 1'b0, '0);
        // stall beats load-use, then the bubble, then the dependent instruction
        i = mk(1, 'h68, 1, 2, 15, 'h1, 'h2, C_LOAD);    e = ld(i, 'h1, 'h2); add(i, 1'b0, e);
        i = mk(1, 'h6C, 15, 3, 5, 'h7, 'h8, C_ALU);
        i.stall = 1'b1;                                 add(i, 1'b0, e);
        i.stall = 1'b0;                                 add(i, 1'b1, '0);
                                                        add(i, 1'b0, ld(i, 'h7, 'h8));
        // invalid decode slot loads a bubble control bundle
        i = mk(0, 'h70, 15, 16, 17, 'hA, 'hB, C_ALU);   add(i, 1'b0, ld(i, 'hA, 'hB));
        // reset during an active load-use hazard, then during a stall
        i = mk(1, 'h74, 1, 2, 16, 'h1, 'h2, C_LOAD);    add(i, 1'b0, ld(i, 'h1, 'h2));
        i = mk(1, 'h78, 3, 16, 6, 'h3, 'h4, C_ALU);
        i.rst = 1'b1;                                   add(i, 1'b1, '0);
        i.rst = 1'b0;                                   add(i, 1'b0, ld(i, 'h3, 'h4));
        i = mk(1, 'h7C, 1, 2, 3, 'h1, 'h2, C_ALU);
        i.flush = 1'b1;                                 add(i, 1'b0, '0);
        i = mk(1, 'h80, 2, 3, 4, 'h2, 'h3, C_ALU);      add(i, 1'b0, ld(i, 'h2, 'h3));
        i.stall = 1'b1; i.rst = 1'b1;                   add(i, 1'b0, '0);

        drive(tbl[0].in);
        @(posedge clk); #1;
        foreach (tbl[k]) begin
            drive(tbl[k].in);
            @(negedge clk);
            cmp($sformatf("vec%0d.hazard_stall", k), 64'(bus.hazard_stall), 64'(tbl[k].haz));
            @(posedge clk); #1;
            check_slot($sformatf("vec%0d", k), tbl[k].exp);
        end

        // ---- random run against the reference model ----
        foreach (rf[r]) rf[r] = {$urandom(), $urandom()};
        rf[0] = '0;
        m = '0;
        for (int c = 0; c < 400; c++) begin
            i        = '0;
            i.rst    = (c == 0) || ($urandom_range(0, 39) == 0);
            i.stall  = ($urandom_range(0, 4) == 0);
            i.flush  = ($urandom_range(0, 9) == 0);
            i.idv    = ($urandom_range(0, 6) != 0);
            i.pc     = {$urandom(), $urandom()};
            i.imm    = {$urandom(), $urandom()};
            i.rs1    = reg_idx_t'($urandom_range(0, 7));
            i.rs2    = reg_idx_t'($urandom_range(0, 7));
            i.rd     = reg_idx_t'($urandom_range(0, 7));
            i.ctrl   = CTRL_W'($urandom());
            i.ctrl[MEMREAD_BIT] = ($urandom_range(0, 4) < 2);
            i.rd1    = rf[i.rs1];
            i.rd2    = rf[i.rs2];
            i.wbwe   = $urandom_range(0, 1) == 1;
            i.wbrd   = reg_idx_t'($urandom_range(0, 7));
            i.wbdata = {$urandom(), $urandom()};
            drive(i);
            @(negedge clk);
            cmp($sformatf("rnd%0d.hazard_stall", c), 64'(bus.hazard_stall), 64'(model_hazard(m, i)));
            @(posedge clk);
            m = model_next(m, i);
            if (i.wbwe && i.wbrd != 0) rf[i.wbrd] = i.wbdata;
            #1;
            check_slot($sformatf("rnd%0d", c), m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register, sitting directly downstream of the register file.
- Captures the register file's combinational read data together with decode fields, and presents registered operands to the EX stage.
- Owns three things:
  - load-use hazard detection and bubble insertion;
  - flush and stall handling;
  - a write-back bypass that covers the register file's write-at-posedge / read-combinational gap.

Parameters:
- XLEN, 64, data/PC width.
- CTRL_W, 12, width of packed decode control bundle.
- MEMREAD_BIT, 3, index of the memread flag inside the control bundle.

Ports:
- clk  in  1  clock, posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  downstream hold; the register keeps its contents.
- flush  in  1  branch-redirect kill; inserts a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  XLEN  decode PC.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_imm  in  XLEN  sign-extended immediate.
- id_readdata1, id_readdata2  in  XLEN  register file read ports.
- id_ctrl  in  CTRL_W  decode control bundle.
- wb_registerwrite  in  1  write-back enable (same signal that drives the register file).
- wb_rd  in  5  write-back destination.
- wb_writedata  in  XLEN  write-back data.
- hazard_stall  out  1  combinational; upstream PC and IF/ID must hold.
- ex_valid  out  1  registered.
- ex_pc, ex_imm, ex_data1, ex_data2  out  XLEN  registered.
- ex_rs1, ex_rs2, ex_rd  out  5  registered.
- ex_ctrl  out  CTRL_W  registered.

Behaviour:
- Reset: every registered output is 0; hazard_stall is therefore 0.
- Latency: one cycle from ID inputs to EX outputs.
- hazard_stall = ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush & ~stall.
- Per-posedge priority:
  1. reset: all outputs cleared.
  2. flush: bubble = ex_valid 0, ex_ctrl 0; other fields don't-care but driven to 0.
  3. stall: hold all fields, except the operand refresh below.
  4. hazard_stall: bubble, as for flush.
  5. otherwise: load every ID field; ex_valid <= id_valid; a load with id_valid 0 forces ex_ctrl to 0.
- Bypass on load: if wb_registerwrite and wb_rd != 0 and wb_rd == id_rs1, capture wb_writedata into ex_data1 instead of id_readdata1. Same rule for rs2 / ex_data2.
- Index 0 is never bypassed. ex_dataN for rs = 0 always takes the register file output.
- Operand refresh during stall: if ex_valid and wb_registerwrite and wb_rd != 0 and wb_rd == ex_rs1, ex_data1 <= wb_writedata. Same rule for rs2. This keeps held operands from going stale.
- Simultaneous flush and stall: flush wins.
- Simultaneous stall and load-use condition: stall wins; hazard_stall stays 0 that cycle.
- Reset mid-stall or mid-hazard clears everything; no stale bubble or hold survives.

Optional Feature:
- Macro IDEX_WB_BYPASS_EN.
- Defined: the load-time bypass and the stall-time operand refresh are as described above.
- Undefined: ex_data1/ex_data2 always capture id_readdata1/id_readdata2 and are held unchanged during stall. The EX forwarding unit must then cover the WB distance.
- hazard_stall is unaffected by the macro.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - XLEN;
  - the control bundle layout (CTRL_W, MEMREAD_BIT, REGWRITE_BIT, MEMWRITE_BIT, ALUOP field);
  - a REG_ZERO constant.
- One natural sub-module: hazard_detect, the combinational load-use comparator driving hazard_stall.
- Bypass muxing and pipeline storage stay in the top module.

Test Plan:
- Reset, then load (pc=0x40, rs1=5, rs2=6, data 0x55/0x66, id_valid=1): next cycle ex_pc=0x40, ex_data1=0x55, ex_data2=0x66, ex_valid=1.
- Load-use: EX holds a load with ex_rd=7 and memread=1; ID has rs2=7 → hazard_stall=1 in that cycle; next cycle ex_valid=0, ex_ctrl=0. Following cycle the ID instruction loads normally.
- Bypass: wb_registerwrite=1, wb_rd=9, wb_writedata=0xDEAD; ID rs1=9, id_readdata1=0x9 → ex_data1=0xDEAD. With the macro undefined, ex_data1=0x9. With wb_rd=0 and rs1=0 → ex_data1=id_readdata1.
- Stall refresh: stall=1 for 2 cycles with ex_rs2=4; WB writes x4=0x1234 in cycle 1 → ex_data2=0x1234; all other fields unchanged and ex_valid held.
- Flush and stall together, with a pending load-use: outputs become a bubble and hazard_stall=0.
- Assert reset during an active hazard/stall sequence: all outputs 0 next cycle.
